regfile_window_sched: RTL and testbench
=======================================

Name: regfile_window_sched

Overview:
- Scheduler in front of the 64-entry, 14-bit pixel register file that holds the 8x8 image tile.
- Shares the bank's single address/write port between two requesters:
  - the image loader, which streams writes;
  - the convolution engine, which requests 3x3 windows.
- Sequences the nine reads of each window, inserting zero padding at tile borders, and returns pixels in raster order with valid/last flags.

Parameters:
- DATA_BIT, 14, pixel width; matches register-file data width.
- IMG_W_LOG, 3, log2 of tile side (8 pixels).
- ADDR_NUM, 6, register-file address width; must equal 2*IMG_W_LOG.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  loader has a pixel.
- load_data  in  DATA_BIT  loader pixel.
- load_ready  out  1  pixel accepted this cycle when high together with load_valid.
- load_done  out  1  one-cycle pulse after the 64th pixel of a tile is written.
- win_start  in  1  window request; sampled only in IDLE.
- win_row  in  IMG_W_LOG  window centre row.
- win_col  in  IMG_W_LOG  window centre column.
- win_busy  out  1  high while in FETCH.
- px_valid  out  1  px_data holds a window pixel.
- px_data  out  DATA_BIT  window pixel, zero for out-of-tile taps.
- px_idx  out  4  tap index 0..8, raster order.
- px_last  out  1  high with tap 8.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_NUM  register-file address, {row,col}.
- rf_wdata  out  DATA_BIT  register-file write data.
- rf_rdata  in  DATA_BIT  register-file read data; combinational from rf_addr.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Load counter = 0. Tap counter = 0.
- Reset takes priority over everything. A reset during FETCH abandons the window with no px_last. A reset mid-load restarts the tile at address 0.
- States: IDLE, FETCH.
- IDLE:
  - If win_start=1, latch win_row/win_col and go to FETCH with tap=0.
  - Else load path is active: load_ready=1, rf_we=load_valid, rf_addr=load counter, rf_wdata=load_data.
- Simultaneous win_start and load_valid in IDLE: the window wins.
  - load_ready = (state==IDLE) & ~win_start, combinational.
  - The loader holds its pixel; no write occurs.
- Load counter:
  - Increments on each accepted write and wraps 63->0.
  - load_done pulses the cycle after the write to address 63.
- FETCH, tap k = 0..8:
  - dr = k/3 - 1, dc = k%3 - 1; r = row+dr, c = col+dc, signed arithmetic with IMG_W_LOG+1 bits.
  - rf_addr = {r[IMG_W_LOG-1:0], c[IMG_W_LOG-1:0]}; rf_we = 0.
  - oob = (r<0) | (r>7) | (c<0) | (c>7).
  - Tap 8 returns to IDLE next cycle.
  - win_busy=1 throughout FETCH; load_ready=0.
- Output stage (registered, latency 1 from the address cycle):
  - px_valid, px_idx, px_last and px_data (= oob ? 0 : rf_rdata) update on the edge ending each FETCH cycle.
  - Window accepted at edge E0: taps visible after edges E1..E9; px_last after E9.
  - px_valid=0 in all other cycles; px_data holds its last value.
- Back-to-back windows:
  - win_start may be asserted in the IDLE cycle that immediately follows FETCH.
  - Minimum window period is 10 cycles, with no gap in the output beyond one cycle.
- No backpressure on px outputs; the consumer must accept every valid pixel.

Optional Feature:
- Macro: WIN_BORDER_REPLICATE_EN.
- Defined: out-of-tile coordinates are clamped to 0..7 (edge replication). px_data = rf_rdata of the clamped address; oob forcing is removed.
- Undefined: zero padding as described in Behaviour.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FETCH);
  - KERNEL_SIZE=3, KERNEL_TAPS=9;
  - TILE_W=8;
  - default DATA_BIT/ADDR_NUM constants shared with the register file.
- One natural sub-module: win_coord_gen. It is purely combinational: (row, col, tap) -> (rf_addr, oob), and contains the clamp path under WIN_BORDER_REPLICATE_EN.

Test Plan:
- Load 64 pixels, value = address+100, with load_valid held high -> rf_we each cycle at addresses 0..63; load_done pulses once, one cycle after address 63; counter wraps to 0.
- After load, win_start with row=3, col=4 -> rf_addr 0x13,0x14,0x15,0x1B,0x1C,0x1D,0x23,0x24,0x25. px_data = those addresses+100, px_idx 0..8, px_last on tap 8, first px_valid 2 cycles after win_start.
- Window at row=0, col=0 -> taps 0,1,2,3,6 output 0. Taps 4,5,7,8 output 100,101,108,109. With WIN_BORDER_REPLICATE_EN, tap 0 outputs 100.
- win_start and load_valid asserted together in IDLE -> load_ready=0, no write that cycle. The pixel is written on the first IDLE cycle after the window, at the unchanged counter address.
- Two back-to-back windows (second win_start in the IDLE cycle right after tap 8) -> 18 px_valid pixels with exactly one idle cycle between the groups.
- rst asserted during tap 4 of a window -> all outputs 0 next cycle, no px_last. The next load writes address 0.

Source files
------------

// File: rtl/regfile_window_sched_pkg.sv
// Shared types and constants for the pixel register-file window scheduler.
// Optional build macro WIN_BORDER_REPLICATE_EN is consumed by the coordinate generator.
package regfile_window_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam int KERNEL_SIZE   = 3;
    localparam int KERNEL_TAPS   = 9;
    localparam int TILE_W        = 8;
    localparam int DEF_DATA_BIT  = 14;
    localparam int DEF_IMG_W_LOG = 3;
    localparam int DEF_ADDR_NUM  = 6;

    function automatic logic is_last_tap(input logic [3:0] tap);
        return tap == 4'(KERNEL_TAPS - 1);
    endfunction

endpackage

// File: rtl/regfile_window_sched_if.sv
// Loader, window-request, pixel-output and register-file bus of the window scheduler.
// The scheduler uses the slave modport; the surrounding system uses master.
interface regfile_window_sched_if
    import regfile_window_sched_pkg::*;
#(
    parameter int DATA_BIT  = DEF_DATA_BIT,
    parameter int IMG_W_LOG = DEF_IMG_W_LOG,
    parameter int ADDR_NUM  = DEF_ADDR_NUM
);
    logic                 load_valid;
    logic [DATA_BIT-1:0]  load_data;
    logic                 load_ready;
    logic                 load_done;
    logic                 win_start;
    logic [IMG_W_LOG-1:0] win_row;
    logic [IMG_W_LOG-1:0] win_col;
    logic                 win_busy;
    logic                 px_valid;
    logic [DATA_BIT-1:0]  px_data;
    logic [3:0]           px_idx;
    logic                 px_last;
    logic                 rf_we;
    logic [ADDR_NUM-1:0]  rf_addr;
    logic [DATA_BIT-1:0]  rf_wdata;
    logic [DATA_BIT-1:0]  rf_rdata;

    modport slave (
        input  load_valid, load_data, win_start, win_row, win_col, rf_rdata,
        output load_ready, load_done, win_busy, px_valid, px_data, px_idx, px_last,
               rf_we, rf_addr, rf_wdata
    );

    modport master (
        output load_valid, load_data, win_start, win_row, win_col, rf_rdata,
        input  load_ready, load_done, win_busy, px_valid, px_data, px_idx, px_last,
               rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/regfile_window_sched_win_coord_gen.sv
// Combinational (row, col, tap) -> (register-file address, out-of-tile flag).
// With WIN_BORDER_REPLICATE_EN defined, border taps clamp to the tile edge instead of flagging.
module regfile_window_sched_win_coord_gen
    import regfile_window_sched_pkg::*;
#(
    parameter int IMG_W_LOG = DEF_IMG_W_LOG
)(
    input  logic [IMG_W_LOG-1:0]   row,
    input  logic [IMG_W_LOG-1:0]   col,
    input  logic [3:0]             tap,
    output logic [2*IMG_W_LOG-1:0] addr,
    output logic                   oob
);
    localparam logic [IMG_W_LOG:0] ONE = {{IMG_W_LOG{1'b0}}, 1'b1};

    logic [1:0]           kr_s;
    logic [1:0]           kc_s;
    logic [IMG_W_LOG:0]   r_s;
    logic [IMG_W_LOG:0]   c_s;
    logic [IMG_W_LOG-1:0] r_sel_s;
    logic [IMG_W_LOG-1:0] c_sel_s;

    // Tap index to kernel row/column position (0..2 each)
    always_comb begin
        kr_s = 2'd1;
        kc_s = 2'd1;
        case (tap)
            4'd0:    begin kr_s = 2'd0; kc_s = 2'd0; end
            4'd1:    begin kr_s = 2'd0; kc_s = 2'd1; end
            4'd2:    begin kr_s = 2'd0; kc_s = 2'd2; end
            4'd3:    begin kr_s = 2'd1; kc_s = 2'd0; end
            4'd4:    begin kr_s = 2'd1; kc_s = 2'd1; end
            4'd5:    begin kr_s = 2'd1; kc_s = 2'd2; end
            4'd6:    begin kr_s = 2'd2; kc_s = 2'd0; end
            4'd7:    begin kr_s = 2'd2; kc_s = 2'd1; end
            4'd8:    begin kr_s = 2'd2; kc_s = 2'd2; end
            default: begin kr_s = 2'd1; kc_s = 2'd1; end
        endcase
    end

    // One extra bit: both -1 and TILE_W land with the top bit set
    assign r_s = {1'b0, row} + {{(IMG_W_LOG-1){1'b0}}, kr_s} - ONE;
    assign c_s = {1'b0, col} + {{(IMG_W_LOG-1){1'b0}}, kc_s} - ONE;

`ifdef WIN_BORDER_REPLICATE_EN
    assign r_sel_s = r_s[IMG_W_LOG] ? ((kr_s == 2'd0) ? '0 : '1) : r_s[IMG_W_LOG-1:0];
    assign c_sel_s = c_s[IMG_W_LOG] ? ((kc_s == 2'd0) ? '0 : '1) : c_s[IMG_W_LOG-1:0];
    assign oob     = 1'b0;
`else
    assign r_sel_s = r_s[IMG_W_LOG-1:0];
    assign c_sel_s = c_s[IMG_W_LOG-1:0];
    assign oob     = r_s[IMG_W_LOG] | c_s[IMG_W_LOG];
`endif

    assign addr = {r_sel_s, c_sel_s};
endmodule

// File: rtl/regfile_window_sched.sv
// Arbitrates the pixel register-file port between the tile loader and 3x3 window fetches.
// Border handling selected by WIN_BORDER_REPLICATE_EN (see coordinate generator).
module regfile_window_sched
    import regfile_window_sched_pkg::*;
#(
    parameter int DATA_BIT  = DEF_DATA_BIT,
    parameter int IMG_W_LOG = DEF_IMG_W_LOG,
    parameter int ADDR_NUM  = DEF_ADDR_NUM
)(
    input  logic                  clk,
    input  logic                  rst,
    regfile_window_sched_if.slave bus
);
    localparam logic [ADDR_NUM-1:0] CNT_ONE = {{(ADDR_NUM-1){1'b0}}, 1'b1};

    state_t               state_r, state_nxt_s;
    logic [3:0]           tap_r, tap_nxt_s;
    logic [IMG_W_LOG-1:0] row_r, col_r;
    logic [ADDR_NUM-1:0]  load_cnt_r;
    logic                 load_done_r;
    logic                 px_valid_r, px_last_r;
    logic [3:0]           px_idx_r;
    logic [DATA_BIT-1:0]  px_data_r;
    logic                 load_ready_s, rf_we_s;
    logic [ADDR_NUM-1:0]  rf_addr_s, coord_addr_s;
    logic [DATA_BIT-1:0]  rf_wdata_s;
    logic                 oob_s;

    regfile_window_sched_win_coord_gen #(.IMG_W_LOG(IMG_W_LOG)) u_coord (
        .row  (row_r),
        .col  (col_r),
        .tap  (tap_r),
        .addr (coord_addr_s),
        .oob  (oob_s)
    );

    // Next state and register-file port mux; a window request blocks the loader
    always_comb begin
        state_nxt_s  = state_r;
        tap_nxt_s    = tap_r;
        load_ready_s = 1'b0;
        rf_we_s      = 1'b0;
        rf_addr_s    = '0;
        rf_wdata_s   = '0;
        case (state_r)
            IDLE: begin
                if (bus.win_start) begin
                    state_nxt_s = FETCH;
                    tap_nxt_s   = 4'd0;
                end else begin
                    load_ready_s = ~rst;
                    rf_we_s      = bus.load_valid & ~rst;
                    rf_addr_s    = load_cnt_r;
                    rf_wdata_s   = bus.load_data;
                end
            end
            FETCH: begin
                rf_addr_s = coord_addr_s;
                if (is_last_tap(tap_r)) begin
                    state_nxt_s = IDLE;
                    tap_nxt_s   = 4'd0;
                end else begin
                    tap_nxt_s = tap_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                tap_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, load counter and registered pixel output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            tap_r       <= 4'd0;
            row_r       <= '0;
            col_r       <= '0;
            load_cnt_r  <= '0;
            load_done_r <= 1'b0;
            px_valid_r  <= 1'b0;
            px_last_r   <= 1'b0;
            px_idx_r    <= 4'd0;
            px_data_r   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            tap_r       <= tap_nxt_s;
            if (state_r == IDLE && bus.win_start) begin
                row_r <= bus.win_row;
                col_r <= bus.win_col;
            end
            if (rf_we_s) begin
                load_cnt_r <= load_cnt_r + CNT_ONE;
            end
            load_done_r <= rf_we_s && (load_cnt_r == {ADDR_NUM{1'b1}});
            px_valid_r  <= (state_r == FETCH);
            px_last_r   <= (state_r == FETCH) && is_last_tap(tap_r);
            if (state_r == FETCH) begin
                px_idx_r  <= tap_r;
                px_data_r <= oob_s ? '0 : bus.rf_rdata;
            end
        end
    end

    assign bus.load_ready = load_ready_s;
    assign bus.load_done  = load_done_r;
    assign bus.win_busy   = (state_r == FETCH);
    assign bus.px_valid   = px_valid_r;
    assign bus.px_last    = px_last_r;
    assign bus.px_idx     = px_idx_r;
    assign bus.px_data    = px_data_r;
    assign bus.rf_we      = rf_we_s;
    assign bus.rf_addr    = rf_addr_s;
    assign bus.rf_wdata   = rf_wdata_s;
endmodule

// File: tb/tb_regfile_window_sched.sv
// Directed, table-driven bench for regfile_window_sched with a behavioural 64x14 register file.
module tb_regfile_window_sched;
    import regfile_window_sched_pkg::*;

    typedef struct {
        logic        ws;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        e_ready;
        logic        e_we;
        logic [5:0]  e_addr;
        logic        e_busy;
        logic        e_pv;
        logic [3:0]  e_idx;
        logic        e_last;
        logic [13:0] e_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    logic [13:0] mem [64];

    regfile_window_sched_if bus ();

    regfile_window_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rf_we) mem[bus.rf_addr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata = mem[bus.rf_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ws, input logic lv, input logic [2:0] row,
                         input logic [2:0] col, input logic [13:0] ld);
        bus.win_start  = ws;
        bus.load_valid = lv;
        bus.win_row    = row;
        bus.win_col    = col;
        bus.load_data  = ld;
    endtask

    function automatic vec_t mk(input logic ws, input logic [2:0] row, input logic [2:0] col,
                                input logic rdy, input logic we, input logic [5:0] addr,
                                input logic busy, input logic pv, input logic [3:0] idx,
                                input logic last, input logic [13:0] data);
        vec_t v;
        v.ws = ws; v.row = row; v.col = col; v.e_ready = rdy; v.e_we = we;
        v.e_addr = addr; v.e_busy = busy; v.e_pv = pv; v.e_idx = idx;
        v.e_last = last; v.e_data = data;
        return v;
    endfunction

    // Twelve cycles per window: request, nine fetch cycles, tap-8 output, quiet cycle
    task automatic add_window(input logic [2:0] row, input logic [2:0] col,
                              input logic [5:0] addr[9], input logic [13:0] data[9]);
        vecs.push_back(mk(1'b1, row, col, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 1'b0, 14'd0));
        for (int k = 0; k < 9; k++) begin
            vecs.push_back(mk(1'b0, row, col, 1'b0, 1'b0, addr[k], 1'b1, k > 0,
                              4'(k - 1), 1'b0, (k > 0) ? data[k-1] : 14'd0));
        end
        vecs.push_back(mk(1'b0, row, col, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 4'd8, 1'b1, data[8]));
        vecs.push_back(mk(1'b0, row, col, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 1'b0, 14'd0));
    endtask

    initial begin
        logic [5:0]  a34[9] = '{6'h13, 6'h14, 6'h15, 6'h1B, 6'h1C, 6'h1D, 6'h23, 6'h24, 6'h25};
        logic [13:0] d34[9] = '{14'd119, 14'd120, 14'd121, 14'd127, 14'd128, 14'd129,
                                14'd135, 14'd136, 14'd137};
`ifdef WIN_BORDER_REPLICATE_EN
        logic [5:0]  a00[9] = '{6'h00, 6'h00, 6'h01, 6'h00, 6'h00, 6'h01, 6'h08, 6'h08, 6'h09};
        logic [13:0] d00[9] = '{14'd100, 14'd100, 14'd101, 14'd100, 14'd100, 14'd101,
                                14'd108, 14'd108, 14'd109};
`else
        logic [5:0]  a00[9] = '{6'h3F, 6'h38, 6'h39, 6'h07, 6'h00, 6'h01, 6'h0F, 6'h08, 6'h09};
        logic [13:0] d00[9] = '{14'd0, 14'd0, 14'd0, 14'd0, 14'd100, 14'd101,
                                14'd0, 14'd108, 14'd109};
`endif
        int nvalid;

        add_window(3'd3, 3'd4, a34, d34);
        add_window(3'd0, 3'd0, a00, d00);

        drive(1'b0, 1'b0, 3'd0, 3'd0, 14'd0);
        step();
        @(negedge clk);
        chk("rst_px_valid", 32'(bus.px_valid), 32'd0);
        chk("rst_px_last",  32'(bus.px_last),  32'd0);
        chk("rst_px_data",  32'(bus.px_data),  32'd0);
        chk("rst_px_idx",   32'(bus.px_idx),   32'd0);
        chk("rst_win_busy", 32'(bus.win_busy), 32'd0);
        chk("rst_load_done",32'(bus.load_done),32'd0);
        chk("rst_rf_we",    32'(bus.rf_we),    32'd0);
        step();
        rst = 1'b0;

        // Full tile load, then two idle cycles to catch the load_done pulse and wrap
        for (int i = 0; i < 66; i++) begin
            drive(1'b0, i < 64, 3'd0, 3'd0, 14'(i + 100));
            @(negedge clk);
            chk("load_ready", 32'(bus.load_ready), 32'd1);
            chk("load_we",    32'(bus.rf_we),      32'(i < 64));
            chk("load_done",  32'(bus.load_done),  32'(i == 64));
            if (i <= 64) chk("load_addr", 32'(bus.rf_addr), 32'(i % 64));
            if (i < 64)  chk("load_wdata", 32'(bus.rf_wdata), 32'(i + 100));
            step();
        end

        foreach (vecs[n]) begin
            drive(vecs[n].ws, 1'b0, vecs[n].row, vecs[n].col, 14'd0);
            @(negedge clk);
            chk("vec_load_ready", 32'(bus.load_ready), 32'(vecs[n].e_ready));
            chk("vec_rf_we",      32'(bus.rf_we),      32'(vecs[n].e_we));
            chk("vec_rf_addr",    32'(bus.rf_addr),    32'(vecs[n].e_addr));
            chk("vec_win_busy",   32'(bus.win_busy),   32'(vecs[n].e_busy));
            chk("vec_px_valid",   32'(bus.px_valid),   32'(vecs[n].e_pv));
            chk("vec_px_last",    32'(bus.px_last),    32'(vecs[n].e_last));
            if (vecs[n].e_pv) begin
                chk("vec_px_idx",  32'(bus.px_idx),  32'(vecs[n].e_idx));
                chk("vec_px_data", 32'(bus.px_data), 32'(vecs[n].e_data));
            end
            step();
        end

        // Window and loader collide in IDLE: window wins, pixel lands afterwards at address 0
        drive(1'b1, 1'b1, 3'd2, 3'd2, 14'd555);
        @(negedge clk);
        chk("coll_ready", 32'(bus.load_ready), 32'd0);
        chk("coll_we",    32'(bus.rf_we),      32'd0);
        step();
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b1, 3'd2, 3'd2, 14'd555);
            @(negedge clk);
            chk("coll_fetch_ready", 32'(bus.load_ready), 32'd0);
            chk("coll_fetch_we",    32'(bus.rf_we),      32'd0);
            step();
        end
        @(negedge clk);
        chk("coll_after_we",    32'(bus.rf_we),      32'd1);
        chk("coll_after_ready", 32'(bus.load_ready), 32'd1);
        chk("coll_after_addr",  32'(bus.rf_addr),    32'd0);
        chk("coll_after_wdata", 32'(bus.rf_wdata),   32'd555);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 14'd0);
        @(negedge clk);
        chk("coll_cnt_next", 32'(bus.rf_addr), 32'd1);
        step();

        // Back-to-back windows: second request in the IDLE cycle showing tap 8
        nvalid = 0;
        for (int c = 0; c < 24; c++) begin
            drive(c == 0 || c == 10, 1'b0, 3'd3, 3'd4, 14'd0);
            @(negedge clk);
            chk("b2b_valid", 32'(bus.px_valid),
                32'((c >= 2 && c <= 10) || (c >= 12 && c <= 20)));
            chk("b2b_last", 32'(bus.px_last), 32'(c == 10 || c == 20));
            if (bus.px_valid) begin
                nvalid++;
                if (c >= 2 && c <= 20 && c != 11) begin
                    chk("b2b_idx",  32'(bus.px_idx),  32'((c <= 10) ? c - 2 : c - 12));
                    chk("b2b_data", 32'(bus.px_data), 32'(d34[(c <= 10) ? c - 2 : c - 12]));
                end
            end
            step();
        end
        chk("b2b_count", 32'(nvalid), 32'd18);

        // Reset during tap 4 abandons the window and restarts the load counter
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 1'b0, 3'd3, 3'd4, 14'd0);
            rst = (c == 5);
            @(negedge clk);
            if (c == 5) chk("rst_tap4_busy", 32'(bus.win_busy), 32'd1);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_px_valid", 32'(bus.px_valid), 32'd0);
        chk("mid_rst_px_last",  32'(bus.px_last),  32'd0);
        chk("mid_rst_px_data",  32'(bus.px_data),  32'd0);
        chk("mid_rst_win_busy", 32'(bus.win_busy), 32'd0);
        step();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", 32'(bus.px_valid), 32'd0);
            chk("mid_rst_no_last",  32'(bus.px_last),  32'd0);
            step();
        end
        drive(1'b0, 1'b1, 3'd0, 3'd0, 14'd777);
        @(negedge clk);
        chk("mid_rst_load_we",   32'(bus.rf_we),   32'd1);
        chk("mid_rst_load_addr", 32'(bus.rf_addr), 32'd0);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 14'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
